// File: rtl/alu_accumulator_sequencer.sv
// Accumulator-side sequencer for the TMP8 datapath: accepts one ALU command per
// valid/ready handshake, drives the external combinational adder and writes back acc/flags.
module alu_accumulator_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic [1:0]       add_mode,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_carry,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_INC = 3'b100,
        OP_DEC = 3'b101,
        OP_CMP = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            opnd_q   <= '0;
            acc_q    <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    opnd_d  = cmd_operand;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // B operand follows the latched op at all times; it reads zero after reset.
    always_comb begin
        add_b = '0;
        unique case (op_q)
            OP_ADD, OP_SUB, OP_CMP: add_b = opnd_q;
            OP_INC, OP_DEC:         add_b = ONE;
            default:                add_b = '0;
        endcase
    end

    always_comb begin
        add_mode = MODE_NONE;
        if (state_q == S_EXEC) begin
            unique case (op_q)
                OP_ADD, OP_INC:         add_mode = MODE_ADD;
                OP_SUB, OP_DEC, OP_CMP: add_mode = MODE_SUB;
                default:                add_mode = MODE_NONE;
            endcase
        end
    end

    // Write-back happens only on the EXEC edge; CMP keeps acc but takes SUB flags.
    always_comb begin
        acc_d    = acc_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (state_q == S_EXEC) begin
            unique case (op_q)
                OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                    acc_d    = add_result;
                    flag_c_d = add_carry;
                    flag_z_d = (add_result == '0);
                    flag_n_d = add_result[WIDTH-1];
                end
                OP_CMP: begin
                    flag_c_d = add_carry;
                    flag_z_d = (add_result == '0);
                    flag_n_d = add_result[WIDTH-1];
                end
                OP_LDA: begin
                    acc_d    = opnd_q;
                    flag_z_d = (opnd_q == '0);
                    flag_n_d = opnd_q[WIDTH-1];
                end
                OP_CLR: begin
                    acc_d    = '0;
                    flag_c_d = 1'b0;
                    flag_z_d = 1'b1;
                    flag_n_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign add_a     = acc_q;
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;

endmodule
